// File: rtl/key_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen_pkg
// Description : State encodings and helpers shared by the set-mode key FSMs.
// Revision    : 1.0  initial release
// ============================================================================
package key_pulse_gen_pkg;

  // Binary 3-bit state encoding, shared with the other set-mode FSMs
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } kp_state_e;

  // The debounced level is high from acceptance of a press until the
  // release has been confirmed.
  function automatic logic state_is_pressed(input kp_state_e s);
    return (s == ST_HELD) || (s == ST_REPEAT) || (s == ST_RELEASE_DB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_pulse_gen_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen_tick_gen
// Description : Free-running prescaler; one-cycle tick every TICK_DIV clocks.
// Revision    : 1.0  initial release
// ============================================================================
module key_pulse_gen_tick_gen #(
  parameter int TICK_DIV  = 50000,
  parameter int CNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Tick is decoded from the registered count, so it is glitch-free
  assign tick = (count_q == C_LAST);

  // Next count: wrap to zero after the last value of the period
  always_comb begin
    count_d = count_q + C_ONE;
    if (count_q == C_LAST) begin
      count_d = '0;
    end
  end

  // Prescaler register, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_pulse_gen
// Description : Debounced push-button to single-clock increment pulses with
//               hold-delayed auto-repeat.
// Revision    : 1.0  initial release
// ============================================================================
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 800,
  parameter int REPEAT_TICKS   = 200,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse,
  output logic pressed
);

  localparam logic [CNT_WIDTH-1:0] C_DEBOUNCE = CNT_WIDTH'(DEBOUNCE_TICKS);
  localparam logic [CNT_WIDTH-1:0] C_HOLD     = CNT_WIDTH'(HOLD_TICKS);
  localparam logic [CNT_WIDTH-1:0] C_REPEAT   = CNT_WIDTH'(REPEAT_TICKS);
  localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 w_key;
  logic                 w_tick;
  logic [CNT_WIDTH-1:0] w_timer_inc;

  kp_state_e            state_q,   state_d;
  logic [CNT_WIDTH-1:0] timer_q,   timer_d;
  logic                 pulse_q,   pulse_d;
  logic                 pressed_q, pressed_d;

  key_pulse_gen_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop synchronizer for the asynchronous pin; idles at released (1)
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign w_key       = ~sync2_q;
  assign w_timer_inc = timer_q + C_ONE;

  // Next-state logic: a key change always takes priority over a tick in
  // the same cycle, so that tick is dropped and no pulse can be issued.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_key) begin
          state_d = ST_PRESS_DB;
          timer_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!w_key) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (w_tick) begin
          if (w_timer_inc == C_DEBOUNCE) begin
            state_d = ST_HELD;
            timer_d = '0;
            pulse_d = 1'b1;
          end else begin
            timer_d = w_timer_inc;
          end
        end
      end
      ST_HELD: begin
        if (!w_key) begin
          state_d = ST_RELEASE_DB;
          timer_d = '0;
        end else if (w_tick) begin
          if (w_timer_inc == C_HOLD) begin
            state_d = ST_REPEAT;
            timer_d = '0;
            pulse_d = 1'b1;
          end else begin
            timer_d = w_timer_inc;
          end
        end
      end
      ST_REPEAT: begin
        if (!w_key) begin
          state_d = ST_RELEASE_DB;
          timer_d = '0;
        end else if (w_tick) begin
          if (w_timer_inc == C_REPEAT) begin
            timer_d = '0;
            pulse_d = 1'b1;
          end else begin
            timer_d = w_timer_inc;
          end
        end
      end
      ST_RELEASE_DB: begin
        // A short return to pressed is a glitch: go back to HELD and
        // restart the hold delay rather than repeating immediately.
        if (w_key) begin
          state_d = ST_HELD;
          timer_d = '0;
        end else if (w_tick) begin
          if (w_timer_inc == C_DEBOUNCE) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = w_timer_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    pressed_d = state_is_pressed(state_d);
  end

  // FSM, timer and registered outputs; reset drops any pending pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  assign pulse   = pulse_q;
  assign pressed = pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_pulse_gen
// Description : Self-checking bench for key_pulse_gen (TICK_DIV=4,
//               DEBOUNCE=2, HOLD=5, REPEAT=3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_pulse_gen;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic key_n   = 1'b0;
  logic pulse;
  logic pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_log[$];
  int exp_log[$];
  logic prev_pulse = 1'b0;
  int pressed_low_seen  = 0;
  int pressed_high_seen = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  kn;
    int    cycles;
    int    exp_pulses;
    logic  exp_pressed;
  } seg_t;

  seg_t tbl[6];

  key_pulse_gen #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (2),
    .HOLD_TICKS     (5),
    .REPEAT_TICKS   (3),
    .CNT_WIDTH      (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .key_n   (key_n),
    .pulse   (pulse),
    .pressed (pressed)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; sample 1 ns after the rising edge and log pulse times
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (pulse === 1'b1) begin
      pulse_log.push_back(cyc);
      check("pulse_one_cycle_wide", int'(prev_pulse), 0);
      check("pressed_with_pulse", int'(pressed), 1);
    end
    if (pressed === 1'b1) pressed_high_seen++;
    else                  pressed_low_seen++;
    prev_pulse = pulse;
  endtask

  task automatic run(input logic r, input logic k, input int n);
    reset = r;
    key_n = k;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    pulse_log.delete();
    pressed_low_seen  = 0;
    pressed_high_seen = 0;
  endtask

  task automatic compare_log(input string name);
    int act;
    check({name, "_pulse_count"}, pulse_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      act = (i < pulse_log.size()) ? pulse_log[i] : -1;
      check($sformatf("%s_pulse%0d_cycle", name, i), act, exp_log[i]);
    end
  endtask

  initial begin
    // Segment table: tests 1 and 2
    tbl[0] = '{"t1_reset_key_down",  1'b1, 1'b0,  3, 0, 1'b0};
    tbl[1] = '{"t1_held_after_rst",  1'b0, 1'b0, 12, 1, 1'b1};
    tbl[2] = '{"t2_reset",           1'b1, 1'b1,  2, 0, 1'b0};
    tbl[3] = '{"t2_idle",            1'b0, 1'b1,  4, 0, 1'b0};
    tbl[4] = '{"t2_clean_press",     1'b0, 1'b0, 12, 1, 1'b1};
    tbl[5] = '{"t2_clean_release",   1'b0, 1'b1, 20, 0, 1'b0};

    for (int s = 0; s < 6; s++) begin
      clear_log();
      run(tbl[s].rst, tbl[s].kn, tbl[s].cycles);
      check({tbl[s].name, "_pulses"}, pulse_log.size(), tbl[s].exp_pulses);
      check({tbl[s].name, "_pressed_end"}, int'(pressed), int'(tbl[s].exp_pressed));
      if (tbl[s].rst) check({tbl[s].name, "_pressed_in_reset"}, pressed_high_seen, 0);
    end

    // Test 3: bounce, 3-cycle toggles never survive two ticks
    run(1'b1, 1'b1, 2);
    clear_log();
    for (int i = 0; i < 14; i++) run(1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, 3);
    run(1'b0, 1'b1, 10);
    check("t3_bounce_pulses", pulse_log.size(), 0);
    check("t3_bounce_pressed_high", pressed_high_seen, 0);

    // Test 4: long hold; first pulse at 8, repeat start +20, then every 12
    run(1'b1, 1'b1, 2);
    cyc = 0;
    clear_log();
    run(1'b0, 1'b0, 100);
    exp_log = '{8, 28, 40, 52, 64, 76, 88, 100};
    compare_log("t4_long_hold");

    // Test 5: 4-cycle release glitch while repeating restarts the hold delay
    clear_log();
    run(1'b0, 1'b1, 4);
    run(1'b0, 1'b0, 24);
    exp_log = '{124};
    compare_log("t5_glitch");
    check("t5_pressed_low_cycles", pressed_low_seen, 0);

    // Test 6: one-cycle reset mid-repeat with key held
    run(1'b1, 1'b0, 1);
    check("t6_pulse_in_reset", int'(pulse), 0);
    check("t6_pressed_in_reset", int'(pressed), 0);
    cyc = 0;
    clear_log();
    run(1'b0, 1'b0, 28);
    exp_log = '{8, 28};
    compare_log("t6_after_reset");
    check("t6_pressed_end", int'(pressed), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
